// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and burst-master FSM state codes.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam int         AXI_ALIGN_B    = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_AR    = 2'd1;
    localparam state_t ST_R     = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/axi_resp_buf.sv
// One-entry registered valid/ready buffer.
// Latency: 1 cycle from input handshake to out_vld.
// Backpressure: in_rdy = !full || out_rdy, so push and pop may share a cycle.
module axi_resp_buf #(
    parameter int W = 66
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         full_q, full_d;
    logic [W-1:0] dat_q, dat_d;

    always_comb begin
        in_rdy = !full_q || out_rdy;
        full_d = full_q;
        dat_d  = dat_q;
        if (in_vld && in_rdy) begin
            full_d = 1'b1;
            dat_d  = in_dat;
        end else if (out_rdy) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
        end
    end

    assign out_vld = full_q;
    assign out_dat = dat_q;

endmodule

// File: rtl/axi_rd_burst_master.sv
// AXI4 read burst initiator: one core request becomes one INCR burst.
// Latency: req handshake -> arvalid next cycle; R beat -> resp_valid next cycle.
// Backpressure: rready follows the one-entry response buffer; next request only after the last beat drains.
module axi_rd_burst_master
    import axi_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 64,
    parameter int                ID_W   = 4,
    parameter logic [ID_W-1:0]   TXN_ID = '0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              resp_err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [ID_W-1:0]   arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              misalign_q, misalign_d;

    logic              buf_in_rdy;
    logic              r_hs;
    logic              is_last;
    logic              beat_err;

    assign is_last = (beat_cnt_q == arlen_q);
    assign rready  = (state_q == ST_R) && buf_in_rdy;
    assign r_hs    = rvalid && rready;

    // A misaligned start address is reported on the first beat only.
    assign beat_err = (rresp != AXI_RESP_OKAY) || (rid != TXN_ID) || (rlast != is_last)
                      || (misalign_q && (beat_cnt_q == 8'd0));

    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        beat_cnt_d = beat_cnt_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    araddr_d   = {req_addr[ADDR_W-1:AXI_ALIGN_B], {AXI_ALIGN_B{1'b0}}};
                    arlen_d    = req_len;
                    beat_cnt_d = 8'd0;
                    misalign_d = |req_addr[AXI_ALIGN_B-1:0];
                    state_d    = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (is_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            default: begin
                if (!resp_valid || resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            araddr_q   <= '0;
            arlen_q    <= '0;
            beat_cnt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            beat_cnt_q <= beat_cnt_d;
            misalign_q <= misalign_d;
        end
    end

    axi_resp_buf #(
        .W(DATA_W + 2)
    ) u_resp_buf (
        .aclk    (aclk),
        .aresetn (aresetn),
        .in_vld  (r_hs),
        .in_rdy  (buf_in_rdy),
        .in_dat  ({rdata, is_last, beat_err}),
        .out_vld (resp_valid),
        .out_rdy (resp_ready),
        .out_dat ({resp_data, resp_last, resp_err})
    );

    // Gated with aresetn so no request is taken while reset is held.
    assign req_ready = (state_q == ST_IDLE) && aresetn;
    assign arvalid   = (state_q == ST_AR);
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arid      = TXN_ID;
    assign arsize    = AXI_SIZE_8B;
    assign arburst   = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Directed, table-driven bench for axi_rd_burst_master with an inline AXI slave and core consumer.
module tb_axi_rd_burst_master;

    logic        aclk;
    logic        aresetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_last;
    logic        resp_err;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int n_cmp = 0;
    int n_bad = 0;

    axi_rd_burst_master #(
        .ADDR_W (32),
        .DATA_W (64),
        .ID_W   (4),
        .TXN_ID (4'd0)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .resp_err   (resp_err),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .arid       (arid),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .rvalid     (rvalid),
        .rready     (rready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // kind: 0 clean, 1 rresp=SLVERR on inj, 2 rid=5 on inj, 3 early rlast on inj
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] base;
        logic [3:0]  rdy;
        int          stall;
        int          kind;
        int          inj;
        logic [31:0] exp_araddr;
        int          err_beat;
        int          exp_done;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        resp_ready = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rid        = '0;
        rdata      = '0;
        rresp      = '0;
        rlast      = 1'b0;
    endtask

    task automatic run_test(input int t, input vec_t v);
        int cyc      = 0;
        int sent     = 0;
        int got      = 0;
        int ar_wait  = 0;
        int ar_hs    = 0;
        int done_cyc = -1;
        int nb       = int'(v.len) + 1;
        bit ar_done  = 1'b0;
        @(negedge aclk);
        while (got < nb && cyc < 1000) begin
            req_valid  = (cyc == 0);
            req_addr   = v.addr;
            req_len    = v.len;
            arready    = !ar_done && (ar_wait >= v.stall);
            rvalid     = ar_done && (sent < nb);
            rdata      = v.base + 64'(sent);
            rresp      = (v.kind == 1 && sent == v.inj) ? 2'b10 : 2'b00;
            rid        = (v.kind == 2 && sent == v.inj) ? 4'd5 : 4'd0;
            rlast      = (sent == int'(v.len)) || (v.kind == 3 && sent == v.inj);
            resp_ready = v.rdy[cyc % 4];
            #1;
            if (cyc == 0) check($sformatf("t%0d req_ready idle", t), 64'(req_ready), 64'd1);
            if (cyc == 1) check($sformatf("t%0d arvalid latency", t), 64'(arvalid), 64'd1);
            if (arvalid) begin
                check($sformatf("t%0d araddr", t), 64'(araddr), 64'(v.exp_araddr));
                check($sformatf("t%0d arlen", t), 64'(arlen), 64'(v.len));
                check($sformatf("t%0d arsize/arburst/arid", t), {55'd0, arsize, arburst, arid}, {55'd0, 3'd3, 2'b01, 4'd0});
                if (arready) begin
                    ar_done = 1'b1;
                    ar_hs++;
                end else begin
                    ar_wait++;
                end
            end
            if (rvalid)
                check($sformatf("t%0d rready", t), 64'(rready), 64'(!(resp_valid && !resp_ready)));
            if (rvalid && rready) sent++;
            if (resp_valid && resp_ready) begin
                check($sformatf("t%0d beat%0d data", t, got), resp_data, v.base + 64'(got));
                check($sformatf("t%0d beat%0d last", t, got), 64'(resp_last), 64'(got == nb - 1));
                check($sformatf("t%0d beat%0d err", t, got), 64'(resp_err), 64'(got == v.err_beat));
                got++;
                done_cyc = cyc;
            end
            cyc++;
            @(negedge aclk);
        end
        check($sformatf("t%0d beats delivered", t), 64'(got), 64'(nb));
        // Extra slave beat offered after the burst must be refused.
        req_valid  = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b1;
        rlast      = 1'b1;
        resp_ready = 1'b1;
        #1;
        check($sformatf("t%0d req_ready after", t), 64'(req_ready), 64'd1);
        check($sformatf("t%0d rready after", t), 64'(rready), 64'd0);
        check($sformatf("t%0d resp_valid after", t), 64'(resp_valid), 64'd0);
        check($sformatf("t%0d ar handshakes", t), 64'(ar_hs), 64'd1);
        check($sformatf("t%0d ar stall cycles", t), 64'(ar_wait), 64'(v.stall));
        if (v.exp_done >= 0)
            check($sformatf("t%0d last resp cycle", t), 64'(done_cyc), 64'(v.exp_done));
        idle_inputs();
    endtask

    initial begin
        tbl[0] = '{32'h8000_0000, 8'd0,   64'h1122_3344_5566_7788, 4'b1111, 0, 0, 0, 32'h8000_0000, -1, 3};
        tbl[1] = '{32'h8000_0100, 8'd3,   64'hD000_0000_0000_0000, 4'b1111, 0, 0, 0, 32'h8000_0100, -1, 6};
        tbl[2] = '{32'h8000_0200, 8'd3,   64'hB000_0000_0000_0010, 4'b1001, 0, 0, 0, 32'h8000_0200, -1, -1};
        tbl[3] = '{32'h8000_0300, 8'd1,   64'h5700_0000_0000_0000, 4'b1111, 5, 0, 0, 32'h8000_0300, -1, 9};
        tbl[4] = '{32'h8000_0400, 8'd2,   64'hE100_0000_0000_0000, 4'b1111, 0, 1, 1, 32'h8000_0400, 1, 5};
        tbl[5] = '{32'h8000_0500, 8'd3,   64'hE200_0000_0000_0000, 4'b1111, 0, 3, 1, 32'h8000_0500, 1, 6};
        tbl[6] = '{32'h8000_0600, 8'd0,   64'hE300_0000_0000_0000, 4'b1111, 0, 2, 0, 32'h8000_0600, 0, 3};
        tbl[7] = '{32'h8000_0705, 8'd1,   64'hA500_0000_0000_0000, 4'b1111, 0, 0, 0, 32'h8000_0700, 0, 4};
        tbl[8] = '{32'h1000_0000, 8'd255, 64'h0F00_0000_0000_0000, 4'b1111, 0, 0, 0, 32'h1000_0000, -1, 258};
        tbl[9] = '{32'h8000_0900, 8'd4,   64'hC000_0000_0000_0000, 4'b0110, 2, 1, 3, 32'h8000_0900, 3, -1};

        idle_inputs();
        aresetn = 1'b0;
        #12;
        check("reset arvalid", 64'(arvalid), 64'd0);
        check("reset rready", 64'(rready), 64'd0);
        check("reset resp_valid/last/err", {61'd0, resp_valid, resp_last, resp_err}, 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd0);
        check("reset araddr", 64'(araddr), 64'd0);
        check("reset arlen", 64'(arlen), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 10; i++) run_test(i, tbl[i]);

        // Reset in the middle of an 8-beat burst, after two beats were accepted.
        @(negedge aclk);
        req_valid = 1'b1;
        req_addr  = 32'h8000_1000;
        req_len   = 8'd7;
        @(negedge aclk);
        req_valid = 1'b0;
        arready   = 1'b1;
        #1;
        check("midrst arvalid", 64'(arvalid), 64'd1);
        @(negedge aclk);
        arready    = 1'b0;
        rvalid     = 1'b1;
        rdata      = 64'h0123_4567_89AB_CDEF;
        resp_ready = 1'b1;
        #1;
        check("midrst rready beat0", 64'(rready), 64'd1);
        @(negedge aclk);
        #1;
        check("midrst rready beat1", 64'(rready), 64'd1);
        @(negedge aclk);
        rvalid     = 1'b0;
        resp_ready = 1'b0;
        #1;
        check("midrst resp_valid before reset", 64'(resp_valid), 64'd1);
        aresetn = 1'b0;
        rvalid  = 1'b1;
        #1;
        check("midrst resp_valid", 64'(resp_valid), 64'd0);
        check("midrst arvalid cleared", 64'(arvalid), 64'd0);
        check("midrst rready cleared", 64'(rready), 64'd0);
        check("midrst req_ready", 64'(req_ready), 64'd0);
        @(negedge aclk);
        @(negedge aclk);
        idle_inputs();
        aresetn = 1'b1;
        run_test(11, tbl[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
